// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_stage
//  Description : Operand-fetch stage feeding the ALU. Holds the NREG x DW
//                register file, selects operands (register / shamt /
//                extended immediate) with EX-stage forwarding and same-cycle
//                writeback bypass, and registers inA/inB/ALUFun/Sign behind a
//                valid/ready handshake with flush.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, reset          : rising-edge clock, asynchronous active-low reset
//    in_valid/in_ready   : upstream handshake (in_ready is independent of
//                          in_valid)
//    rs, rt, shamt, imm  : instruction fields
//    ExtOp, LUOp         : immediate extension control (LUOp wins)
//    ALUSrc1, ALUSrc2    : operand source selects
//    ALUFun_in, Sign_in  : passed through to the ALU
//    flush               : squash output and incoming instruction
//    fwd_en/addr/data    : EX-stage result forward
//    wd_en/addr/data     : register-file writeback
//    out_valid/out_ready : downstream handshake
//    inA, inB, ALUFun, Sign : registered ALU inputs
// ============================================================================
module alu_operand_stage #(
    parameter int NREG = 32,
    parameter int DW   = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    rs,
    input  logic [4:0]    rt,
    input  logic [4:0]    shamt,
    input  logic [15:0]   imm,
    input  logic          ExtOp,
    input  logic          LUOp,
    input  logic          ALUSrc1,
    input  logic          ALUSrc2,
    input  logic [5:0]    ALUFun_in,
    input  logic          Sign_in,
    input  logic          flush,
    input  logic          fwd_en,
    input  logic [4:0]    fwd_addr,
    input  logic [DW-1:0] fwd_data,
    input  logic          wd_en,
    input  logic [4:0]    wd_addr,
    input  logic [DW-1:0] wd_data,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] inA,
    output logic [DW-1:0] inB,
    output logic [5:0]    ALUFun,
    output logic          Sign
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] rf_q [NREG];
    logic [DW-1:0] rf_d [NREG];
    logic [DW-1:0] ina_q, ina_d;
    logic [DW-1:0] inb_q, inb_d;
    logic [5:0]    alufun_q, alufun_d;
    logic          sign_q, sign_d;

    logic [DW-1:0] rs_val;
    logic [DW-1:0] rt_val;
    logic [DW-1:0] imm_ext;
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    logic          accept;

    // Read-port bypass: register 0 is always zero, then the youngest value
    // (EX forward) beats the writeback that is landing this very cycle.
    function automatic logic [DW-1:0] read_port(
        input logic [4:0]    addr,
        input logic [DW-1:0] arr_val,
        input logic          f_en,
        input logic [4:0]    f_addr,
        input logic [DW-1:0] f_data,
        input logic          w_en,
        input logic [4:0]    w_addr,
        input logic [DW-1:0] w_data
    );
        logic [DW-1:0] val;
        if (addr == 5'd0) begin
            val = '0;
        end else if (f_en && (f_addr == addr)) begin
            val = f_data;
        end else if (w_en && (w_addr == addr)) begin
            val = w_data;
        end else begin
            val = arr_val;
        end
        return val;
    endfunction

    always_comb begin
        rs_val = read_port(rs, rf_q[rs], fwd_en, fwd_addr, fwd_data,
                           wd_en, wd_addr, wd_data);
        rt_val = read_port(rt, rf_q[rt], fwd_en, fwd_addr, fwd_data,
                           wd_en, wd_addr, wd_data);
    end

    always_comb begin
        if (LUOp) begin
            imm_ext = {imm, {(DW-16){1'b0}}};
        end else if (ExtOp) begin
            imm_ext = {{(DW-16){imm[15]}}, imm};
        end else begin
            imm_ext = {{(DW-16){1'b0}}, imm};
        end
    end

    // Shift amount travels on inA; the value being shifted on inB.
    assign opa = ALUSrc1 ? {{(DW-5){1'b0}}, shamt} : rs_val;
    assign opb = ALUSrc2 ? imm_ext : rt_val;

    assign out_valid = (state_q == ST_FULL);
    assign in_ready  = !flush && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;

    // Register-file write; register 0 is never written so it stays zero.
    always_comb begin
        rf_d = rf_q;
        if (wd_en && (wd_addr != 5'd0)) begin
            rf_d[wd_addr] = wd_data;
        end
    end

    // Control FSM and output-register next state. flush dominates because
    // accept already excludes it and the FULL branch checks it first.
    always_comb begin
        state_d  = state_q;
        ina_d    = ina_q;
        inb_d    = inb_q;
        alufun_d = alufun_q;
        sign_d   = sign_q;

        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (flush) begin
                    state_d = ST_EMPTY;
                end else if (out_ready && !in_valid) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        if (accept) begin
            ina_d    = opa;
            inb_d    = opb;
            alufun_d = ALUFun_in;
            sign_d   = Sign_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_EMPTY;
            ina_q    <= '0;
            inb_q    <= '0;
            alufun_q <= '0;
            sign_q   <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            ina_q    <= ina_d;
            inb_q    <= inb_d;
            alufun_q <= alufun_d;
            sign_q   <= sign_d;
            rf_q     <= rf_d;
        end
    end

    assign inA    = ina_q;
    assign inB    = inb_q;
    assign ALUFun = alufun_q;
    assign Sign   = sign_q;

endmodule
`default_nettype wire
